// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: multi-cycle RV32I main control FSM with memory handshake and traps.
// Rev 1.0
`default_nettype none

module riscv_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int RET_W       = 32,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [6:0]         opcode_in,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               branch,
  output logic [1:0]         fetch_pc,
  output logic               ir_write,
  output logic               pc_write,
  output logic               instr_done,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               timeout,
  output logic [RET_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [RET_W-1:0] retired_q;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             is_lw, is_s, is_b, legal;
  logic             src_dec, br_dec;
  logic [2:0]       op_dec;
  logic [1:0]       fpc_dec;
  logic [TO_W-1:0]  wait_inc;
  state_t           boundary;

  // Decode of the latched opcode only; opcode_in never reaches the outputs.
  always_comb begin
    legal   = 1'b1;
    src_dec = 1'b0;
    br_dec  = 1'b0;
    op_dec  = 3'b000;
    fpc_dec = 2'b00;
    case (opc_q)
      OP_R:     op_dec = 3'b100;
      OP_IMM:   begin op_dec = 3'b010; src_dec = 1'b1; end
      OP_LW:    begin op_dec = 3'b101; src_dec = 1'b1; end
      OP_S:     begin op_dec = 3'b101; src_dec = 1'b1; end
      OP_B:     begin op_dec = 3'b001; br_dec  = 1'b1; end
      OP_LUI:   src_dec = 1'b1;
      OP_AUIPC: begin src_dec = 1'b1; fpc_dec = 2'b10; end
      OP_JAL:   begin op_dec = 3'b011; br_dec = 1'b1; fpc_dec = 2'b01; end
      default:  legal = 1'b0;
    endcase
  end

  assign is_lw    = (opc_q == OP_LW);
  assign is_s     = (opc_q == OP_S);
  assign is_b     = (opc_q == OP_B);
  assign wait_inc = wait_q + TO_W'(1);
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    fetch_pc   = 2'b00;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          opc_d    = opcode_in;
          state_d  = S_DECODE;
        end else if (wait_inc == TO_W'(MEM_TIMEOUT)) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src  = src_dec;
        alu_op   = ALUOP_W'(op_dec);
        branch   = br_dec;
        fetch_pc = fpc_dec;
        if (is_lw || is_s) begin
          state_d = S_MEM;
        end else if (is_b) begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_d    = boundary;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_read  = is_lw;
        mem_write = is_s;
        alu_src   = src_dec;
        alu_op    = ALUOP_W'(op_dec);
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = boundary;
          end
        end else if (wait_inc == TO_W'(MEM_TIMEOUT)) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        fetch_pc   = fpc_dec;
        state_d    = boundary;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opc_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (instr_done) retired_q <= retired_q + RET_W'(1);
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for riscv_multicycle_control with a retirement scoreboard.
// Rev 1.0
`default_nettype none

module tb_riscv_multicycle_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [6:0]  opcode_in;
  logic        mem_req, mem_read, mem_write, mem_to_reg, alu_src;
  logic [2:0]  alu_op;
  logic        reg_write, branch, ir_write, pc_write, instr_done;
  logic [1:0]  fetch_pc;
  logic [2:0]  state;
  logic        illegal, timeout;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;
  int lat_cnt = 0;

  typedef struct {
    int          lat;
    logic [31:0] ret;
  } exp_t;
  exp_t sb[$];

  riscv_multicycle_control #(
    .MEM_TIMEOUT(15), .TO_W(4), .RET_W(32), .ALUOP_W(3)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .opcode_in(opcode_in), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .branch(branch), .fetch_pc(fetch_pc),
    .ir_write(ir_write), .pc_write(pc_write), .instr_done(instr_done),
    .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs on the falling edge, settle, then let the caller check.
  task automatic tick(input logic rdy, input logic [6:0] opc);
    @(negedge clk);
    mem_ready = rdy;
    opcode_in = opc;
    #1;
  endtask

  task automatic push(input int lat, input logic [31:0] ret);
    exp_t e;
    e.lat = lat;
    e.ret = ret;
    sb.push_back(e);
  endtask

  // Retirement monitor: latency from the IR-latch cycle to instr_done, and count before retiring.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      lat_cnt = 0;
    end else begin
      if (ir_write) lat_cnt = 1;
      else if (lat_cnt > 0) lat_cnt++;
      if (instr_done) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_latency", 32'(lat_cnt), 32'(e.lat));
          chk("sb_retired", retired, e.ret);
        end
        lat_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_flags", {illegal, timeout, mem_req, pc_write}, 32'd0);
    rst = 1'b0; run = 1'b1;

    // R-type, memory always ready
    tick(1'b1, OP_R); push(4, 32'd0);
    chk("r_fetch_state", 32'(state), 32'd1);
    chk("r_fetch_req", {mem_req, mem_read, ir_write}, 32'b111);
    tick(1'b1, '0); chk("r_decode", 32'(state), 32'd2);
    tick(1'b1, '0); chk("r_exec", 32'(state), 32'd3);
    chk("r_exec_alu", {alu_src, alu_op}, 32'b0100);
    tick(1'b1, '0); chk("r_wb", 32'(state), 32'd5);
    chk("r_wb_ctl", {reg_write, pc_write, mem_to_reg, instr_done}, 32'b1101);

    // LW with memory-stage ready delayed 3 cycles
    tick(1'b1, OP_LW); push(8, 32'd1);
    chk("lw_refetch", 32'(state), 32'd1);
    chk("lw_retired_r", retired, 32'd1);
    tick(1'b0, '0); tick(1'b0, '0);
    chk("lw_exec_alu", {alu_src, alu_op}, 32'b1101);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0);
      chk("lw_mem_wait", {state, mem_req, mem_read, mem_write, pc_write, alu_op}, 32'b100_1100_101);
    end
    tick(1'b1, '0);
    chk("lw_mem_done", {state, mem_req, mem_read, pc_write, alu_op}, 32'b100_110_101);
    tick(1'b0, '0);
    chk("lw_wb", {state, mem_to_reg, reg_write, pc_write}, 32'b101_111);

    // S then B
    tick(1'b1, OP_S); push(4, 32'd2);
    tick(1'b0, '0); tick(1'b0, '0);
    chk("s_exec", {state, alu_src, alu_op}, 32'b011_1101);
    tick(1'b1, '0);
    chk("s_mem", {state, mem_write, mem_read, reg_write, pc_write, instr_done}, 32'b100_10011);
    tick(1'b1, OP_B); push(3, 32'd3);
    chk("b_fetch", 32'(state), 32'd1);
    tick(1'b0, '0); tick(1'b0, '0);
    chk("b_exec", {state, branch, alu_op, pc_write, instr_done}, 32'b011_1001_11);

    // JAL then AUIPC
    tick(1'b1, OP_JAL); push(4, 32'd4);
    chk("jal_retired_b", retired, 32'd4);
    tick(1'b0, '0); tick(1'b0, '0);
    chk("jal_exec", {state, fetch_pc, alu_op, branch, alu_src}, 32'b011_01_011_10);
    tick(1'b0, '0);
    chk("jal_wb", {state, fetch_pc, reg_write, branch}, 32'b101_01_10);
    tick(1'b1, OP_AUIPC); push(4, 32'd5);
    tick(1'b0, '0); tick(1'b0, '0);
    chk("auipc_exec", {state, fetch_pc, alu_op, alu_src}, 32'b011_10_000_1);
    tick(1'b0, '0);
    chk("auipc_wb", {state, fetch_pc}, 32'b101_10);

    // run dropped mid R-type: completes, then IDLE
    tick(1'b1, OP_R); push(4, 32'd6);
    tick(1'b0, '0);
    run = 1'b0;
    tick(1'b0, '0); chk("stop_exec", 32'(state), 32'd3);
    tick(1'b0, '0); chk("stop_wb", {state, instr_done}, 32'b101_1);
    tick(1'b0, '0);
    chk("stop_idle", {state, mem_req}, 32'b000_0);
    chk("stop_retired", retired, 32'd7);
    tick(1'b1, OP_R);
    chk("idle_ready_ignored", {state, ir_write, mem_req}, 32'b000_00);

    // fetch timeout
    run = 1'b1;
    tick(1'b0, '0);
    chk("to_first", {state, mem_req}, 32'b001_1);
    for (int i = 1; i < 15; i++) begin
      tick(1'b0, '0);
      chk("to_wait", 32'(state), 32'd1);
    end
    tick(1'b0, '0);
    chk("to_trap", {state, timeout, mem_req, mem_read}, 32'b110_100);
    tick(1'b1, OP_R);
    chk("to_hold", {state, timeout, ir_write}, 32'b110_10);
    rst = 1'b1; #1;
    chk("to_rst", {state, timeout, illegal}, 32'b000_00);
    chk("to_rst_ret", retired, 32'd0);

    // illegal opcode
    @(negedge clk); rst = 1'b0;
    tick(1'b1, OP_BAD);
    chk("ill_fetch", {state, ir_write}, 32'b001_1);
    tick(1'b0, '0); chk("ill_decode", 32'(state), 32'd2);
    tick(1'b0, '0);
    chk("ill_trap", {state, illegal, mem_req, alu_op, reg_write, pc_write}, 32'b110_10_000_00);
    tick(1'b1, OP_R);
    chk("ill_hold", {state, illegal}, 32'b110_1);
    rst = 1'b1; #1;
    chk("ill_rst", {state, illegal}, 32'b000_0);

    // asynchronous reset abandons an in-flight fetch
    @(negedge clk); rst = 1'b0;
    tick(1'b0, '0);
    chk("arst_pre", {state, mem_req}, 32'b001_1);
    #2 rst = 1'b1; #1;
    chk("arst_drop", {state, mem_req, mem_read}, 32'b000_00);
    @(negedge clk); rst = 1'b0; run = 1'b0;
    tick(1'b0, '0);
    chk("arst_idle", 32'(state), 32'd0);

    @(negedge clk); #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
